// File: rtl/iter_divider.sv
// Iterative restoring radix-2 divider.
// Operands arrive on two independent valid/ready channels. Once both are
// present, one quotient bit is produced per cycle. The result is then
// presented with a single-cycle valid pulse. With SIGNED set, the divide
// follows two's-complement rules: the quotient is negative when the operand
// signs differ, and the remainder takes the sign of the dividend.
module iter_divider #(
    parameter int WIDTH  = 32,
    parameter int SIGNED = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     s_axis_dividend_tdata,
    input  logic                 s_axis_dividend_tvalid,
    output logic                 s_axis_dividend_tready,
    input  logic [WIDTH-1:0]     s_axis_divisor_tdata,
    input  logic                 s_axis_divisor_tvalid,
    output logic                 s_axis_divisor_tready,
    output logic [2*WIDTH-1:0]   m_axis_dout_tdata,
    output logic                 m_axis_dout_tvalid
);

    localparam int CW       = $clog2(WIDTH + 1);
    localparam bit IsSigned = (SIGNED != 0);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic               dvdHeld_q, dvdHeld_d;
    logic               dvsHeld_q, dvsHeld_d;
    logic [WIDTH-1:0]   dvdReg_q, dvdReg_d;
    logic [WIDTH-1:0]   dvsReg_q, dvsReg_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [CW-1:0]      count_q, count_d;
    logic               negQ_q, negQ_d;
    logic               negR_q, negR_d;
    logic [2*WIDTH-1:0] dout_q, dout_d;

    logic               dvdFire, dvsFire;
    logic [WIDTH-1:0]   dvdVal, dvsVal;
    logic               dvdNeg, dvsNeg;
    logic [WIDTH:0]     shifted, trial;
    logic               qBit;
    logic [WIDTH-1:0]   remStep, quoStep;
    logic [WIDTH-1:0]   quoFinal, remFinal;

    assign s_axis_dividend_tready = (state_q == IDLE) && !dvdHeld_q;
    assign s_axis_divisor_tready  = (state_q == IDLE) && !dvsHeld_q;
    assign m_axis_dout_tvalid     = (state_q == DONE);
    assign m_axis_dout_tdata      = dout_q;

    // Operand selection and one restoring step. The step is done at WIDTH+1
    // bits so that a full-width remainder shifted left keeps its top bit.
    always_comb begin
        dvdFire  = s_axis_dividend_tvalid && s_axis_dividend_tready;
        dvsFire  = s_axis_divisor_tvalid && s_axis_divisor_tready;
        dvdVal   = dvdHeld_q ? dvdReg_q : s_axis_dividend_tdata;
        dvsVal   = dvsHeld_q ? dvsReg_q : s_axis_divisor_tdata;
        dvdNeg   = IsSigned && dvdVal[WIDTH-1];
        dvsNeg   = IsSigned && dvsVal[WIDTH-1];
        shifted  = {rem_q, a_q[WIDTH-1]};
        trial    = shifted - {1'b0, b_q};
        qBit     = !trial[WIDTH];
        remStep  = qBit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quoStep  = {a_q[WIDTH-2:0], qBit};
        quoFinal = negQ_q ? -quoStep : quoStep;
        remFinal = negR_q ? -remStep : remStep;
    end

    // Next-state logic: operand capture in IDLE, bit iteration in CALC and
    // a single result cycle in DONE.
    always_comb begin
        state_d   = state_q;
        dvdHeld_d = dvdHeld_q;
        dvsHeld_d = dvsHeld_q;
        dvdReg_d  = dvdReg_q;
        dvsReg_d  = dvsReg_q;
        a_d       = a_q;
        b_d       = b_q;
        rem_d     = rem_q;
        count_d   = count_q;
        negQ_d    = negQ_q;
        negR_d    = negR_q;
        dout_d    = dout_q;
        unique case (state_q)
            IDLE: begin
                if (dvdFire) begin
                    dvdReg_d  = s_axis_dividend_tdata;
                    dvdHeld_d = 1'b1;
                end
                if (dvsFire) begin
                    dvsReg_d  = s_axis_divisor_tdata;
                    dvsHeld_d = 1'b1;
                end
                if ((dvdHeld_q || dvdFire) && (dvsHeld_q || dvsFire)) begin
                    a_d       = dvdNeg ? -dvdVal : dvdVal;
                    b_d       = dvsNeg ? -dvsVal : dvsVal;
                    rem_d     = '0;
                    count_d   = CW'(WIDTH);
                    negQ_d    = dvdNeg ^ dvsNeg;
                    negR_d    = dvdNeg;
                    dvdHeld_d = 1'b0;
                    dvsHeld_d = 1'b0;
                    state_d   = CALC;
                end
            end
            CALC: begin
                rem_d   = remStep;
                a_d     = quoStep;
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    dout_d  = {quoFinal, remFinal};
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with asynchronous clear; the result register is only
    // cleared by reset and otherwise holds until the next result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            dvdHeld_q <= 1'b0;
            dvsHeld_q <= 1'b0;
            dvdReg_q  <= '0;
            dvsReg_q  <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rem_q     <= '0;
            count_q   <= '0;
            negQ_q    <= 1'b0;
            negR_q    <= 1'b0;
            dout_q    <= '0;
        end else begin
            state_q   <= state_d;
            dvdHeld_q <= dvdHeld_d;
            dvsHeld_q <= dvsHeld_d;
            dvdReg_q  <= dvdReg_d;
            dvsReg_q  <= dvsReg_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rem_q     <= rem_d;
            count_q   <= count_d;
            negQ_q    <= negQ_d;
            negR_q    <= negR_d;
            dout_q    <= dout_d;
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// Scoreboard bench for iter_divider: one unsigned and one signed instance.
module tb_iter_divider;

    localparam int W = 32;

    typedef struct {
        logic [63:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cycle = 0;
    int   checks = 0;
    int   failures = 0;

    logic [31:0] uDvdData, uDvsData, sDvdData, sDvsData;
    logic        uDvdValid, uDvsValid, sDvdValid, sDvsValid;
    logic        uDvdReady, uDvsReady, sDvdReady, sDvsReady;
    logic [63:0] uData, sData;
    logic        uValid, sValid;

    exp_t        sbU[$];
    exp_t        sbS[$];
    logic [63:0] lastData [2];
    logic        prevValid [2];

    iter_divider #(.WIDTH(W), .SIGNED(0)) dutU (
        .clk                    (clk),
        .reset                  (reset),
        .s_axis_dividend_tdata  (uDvdData),
        .s_axis_dividend_tvalid (uDvdValid),
        .s_axis_dividend_tready (uDvdReady),
        .s_axis_divisor_tdata   (uDvsData),
        .s_axis_divisor_tvalid  (uDvsValid),
        .s_axis_divisor_tready  (uDvsReady),
        .m_axis_dout_tdata      (uData),
        .m_axis_dout_tvalid     (uValid)
    );

    iter_divider #(.WIDTH(W), .SIGNED(1)) dutS (
        .clk                    (clk),
        .reset                  (reset),
        .s_axis_dividend_tdata  (sDvdData),
        .s_axis_dividend_tvalid (sDvdValid),
        .s_axis_dividend_tready (sDvdReady),
        .s_axis_divisor_tdata   (sDvsData),
        .s_axis_divisor_tvalid  (sDvsValid),
        .s_axis_divisor_tready  (sDvsReady),
        .m_axis_dout_tdata      (sData),
        .m_axis_dout_tvalid     (sValid)
    );

    // Free-running clock and a cycle counter that advances on each rising edge.
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkEq(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Compare one instance's output at a falling edge against its scoreboard.
    task automatic checkOutput(input int idx, input logic valid, input logic [63:0] data);
        exp_t e;
        int   depth;
        depth = (idx == 0) ? sbU.size() : sbS.size();
        if (valid) begin
            if (depth == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpectedPulse%0d: got tdata %h expected no pulse", idx, data);
            end else begin
                if (idx == 0) e = sbU.pop_front();
                else          e = sbS.pop_front();
                checkEq($sformatf("result%0d", idx), data, e.data);
                checkEq($sformatf("latency%0d", idx), 64'(cycle), 64'(e.due));
                lastData[idx] = e.data;
            end
            checkEq($sformatf("pulseWidth%0d", idx), 64'(prevValid[idx]), 64'd0);
        end else begin
            checkEq($sformatf("tdataStable%0d", idx), data, lastData[idx]);
        end
        prevValid[idx] = valid;
    endtask

    // Monitor: checks both instances on every falling edge, away from the active edge.
    always @(negedge clk) begin
        if (reset) begin
            lastData[0]  = '0;
            lastData[1]  = '0;
            prevValid[0] = 1'b0;
            prevValid[1] = 1'b0;
        end else begin
            checkOutput(0, uValid, uData);
            checkOutput(1, sValid, sData);
        end
    end

    // Offer both operands together and hold them until accepted; optionally
    // record the expected result and its due cycle in the scoreboard.
    task automatic applyStimulus(input bit sel, input logic [31:0] dvd, input logic [31:0] dvs,
                                 input logic [63:0] exp, input bit track, output int capCycle);
        bit   done;
        bit   rdy;
        int   waitCnt;
        exp_t e;
        @(negedge clk);
        if (sel) begin
            sDvdData = dvd; sDvsData = dvs; sDvdValid = 1'b1; sDvsValid = 1'b1;
        end else begin
            uDvdData = dvd; uDvsData = dvs; uDvdValid = 1'b1; uDvsValid = 1'b1;
        end
        done     = 1'b0;
        waitCnt  = 0;
        capCycle = -1;
        while (!done) begin
            rdy = sel ? (sDvdReady && sDvsReady) : (uDvdReady && uDvsReady);
            if (rdy) begin
                capCycle = cycle + 1;
                if (track) begin
                    e.data = exp;
                    e.due  = capCycle + W;
                    if (sel) sbS.push_back(e);
                    else     sbU.push_back(e);
                end
                done = 1'b1;
            end else if (waitCnt > 100) begin
                checks++;
                failures++;
                $display("[TB] FAIL handshakeTimeout: got tready low expected acceptance within 100 cycles");
                done = 1'b1;
            end
            @(negedge clk);
            waitCnt++;
        end
        if (sel) begin
            sDvdValid = 1'b0; sDvsValid = 1'b0;
        end else begin
            uDvdValid = 1'b0; uDvsValid = 1'b0;
        end
    endtask

    // Wait, with a bound, until every expected result has been seen.
    task automatic waitIdle();
        int n;
        n = 0;
        while ((sbU.size() != 0 || sbS.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("[TB] FAIL drainTimeout: got %0d/%0d pending expected 0", sbU.size(), sbS.size());
            sbU.delete();
            sbS.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Directed test sequence.
    initial begin
        int capA;
        int capB;
        exp_t e;
        uDvdData = '0; uDvsData = '0; uDvdValid = 1'b0; uDvsValid = 1'b0;
        sDvdData = '0; sDvsData = '0; sDvdValid = 1'b0; sDvsValid = 1'b0;

        repeat (3) @(negedge clk);
        checkEq("resetValid", {62'd0, uValid, sValid}, 64'd0);
        checkEq("resetDataU", uData, 64'd0);
        checkEq("resetDataS", sData, 64'd0);
        #2 reset = 1'b0;
        #1;
        checkEq("resetReady", {60'd0, uDvdReady, uDvsReady, sDvdReady, sDvsReady}, 64'hF);

        applyStimulus(0, 32'd100, 32'd7, 64'h0000000E_00000002, 1, capA);
        applyStimulus(1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFD_FFFFFFFF, 1, capB);
        applyStimulus(0, 32'd5, 32'd0, 64'hFFFFFFFF_00000005, 1, capA);
        applyStimulus(1, 32'd7, 32'hFFFFFFFE, 64'hFFFFFFFD_00000001, 1, capB);
        applyStimulus(1, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, 1, capB);
        applyStimulus(1, 32'hFFFFFF9C, 32'hFFFFFFF9, 64'h0000000E_FFFFFFFE, 1, capB);
        applyStimulus(1, 32'hFFFFFFFB, 32'd0, 64'h00000001_FFFFFFFB, 1, capB);

        applyStimulus(0, 32'hFFFFFFFF, 32'h00000010, 64'h0FFFFFFF_0000000F, 1, capA);
        applyStimulus(0, 32'hFFFFFFFF, 32'h80000001, 64'h00000001_7FFFFFFE, 1, capB);
        checkEq("throughput", 64'(capB - capA), 64'(W + 2));
        waitIdle();

        // Staggered handshake on the signed instance: 100 / -7.
        checkEq("staggerDvdReady", {63'd0, sDvdReady}, 64'd1);
        sDvdData = 32'd100;
        sDvdValid = 1'b1;
        @(negedge clk);
        sDvdValid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            checkEq("staggerDvdBusy", {63'd0, sDvdReady}, 64'd0);
            checkEq("staggerDvsOpen", {63'd0, sDvsReady}, 64'd1);
            if (i < 3) @(negedge clk);
        end
        sDvsData = 32'hFFFFFFF9;
        sDvsValid = 1'b1;
        e.data = 64'hFFFFFFF2_00000002;
        e.due  = cycle + 1 + W;
        sbS.push_back(e);
        @(negedge clk);
        sDvsValid = 1'b0;
        for (int i = 0; i <= W; i++) begin
            checkEq("busyReady", {62'd0, sDvdReady, sDvsReady}, 64'd0);
            @(negedge clk);
        end
        checkEq("reopenReady", {62'd0, sDvdReady, sDvsReady}, 64'd3);
        waitIdle();

        // Asynchronous reset in the middle of an unsigned divide (count = 10).
        applyStimulus(0, 32'd1000, 32'd10, 64'd0, 0, capA);
        while (cycle < capA + 22) @(negedge clk);
        #2 reset = 1'b1;
        #2;
        checkEq("midResetValid", {63'd0, uValid}, 64'd0);
        checkEq("midResetData", uData, 64'd0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checkEq("postResetReady", {62'd0, uDvdReady, uDvsReady}, 64'd3);
        repeat (40) @(negedge clk);

        applyStimulus(0, 32'd9, 32'd3, 64'h00000003_00000000, 1, capA);
        waitIdle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL globalTimeout: got still running expected finish");
        $fatal(1, "[TB] time limit reached");
    end

endmodule
